// File: rtl/axi_bridge_wr_arbiter_pkg.sv
// Shared widths, payload layouts, response codes and CID helpers for the 2:1 AXI3 write arbiter.
package axi_bridge_wr_arbiter_pkg;

    localparam int unsigned AXI_WIDTH_CID = 4;
    localparam int unsigned AXI_WIDTH_ID  = 4;
    localparam int unsigned AXI_WIDTH_AD  = 32;
    localparam int unsigned AXI_WIDTH_DA  = 32;
    localparam int unsigned AXI_WIDTH_DS  = AXI_WIDTH_DA / 8;
    localparam int unsigned AXI_WIDTH_SID = AXI_WIDTH_CID + AXI_WIDTH_ID;

    // AW control tail: AWLEN[4], AWLOCK[2], AWSIZE[3], AWBURST[2]
    localparam int unsigned AW_CTRL_W = 4 + 2 + 3 + 2;

    localparam int unsigned AWU = AXI_WIDTH_ID  + AXI_WIDTH_AD + AW_CTRL_W;
    localparam int unsigned AWM = AXI_WIDTH_SID + AXI_WIDTH_AD + AW_CTRL_W;
    localparam int unsigned WU  = AXI_WIDTH_ID  + AXI_WIDTH_DA + AXI_WIDTH_DS + 1;
    localparam int unsigned WM  = AXI_WIDTH_SID + AXI_WIDTH_DA + AXI_WIDTH_DS + 1;
    localparam int unsigned BU  = AXI_WIDTH_ID  + 2;
    localparam int unsigned BM  = AXI_WIDTH_SID + 2;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } bresp_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } aw_state_e;

    function automatic logic [AXI_WIDTH_CID-1:0] cid_enc(input logic idx);
        return AXI_WIDTH_CID'(idx);
    endfunction

    function automatic logic [AXI_WIDTH_CID-1:0] cid_dec(input logic [BM-1:0] bpay);
        return bpay[BM-1 -: AXI_WIDTH_CID];
    endfunction

endpackage

// File: rtl/axi_bridge_wr_arb_fifo.sv
// Order FIFO holding the requester index of each granted AW until its WLAST passes.
module axi_bridge_wr_arb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_din,
    input  logic          i_pop,
    output logic [DW-1:0] o_head_c,
    output logic          o_full_c,
    output logic          o_empty_c
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;

    // Power-of-2 depth lets the pointers wrap naturally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_din;
                r_wp        <= r_wp + PW'(1);
            end
            if (i_pop) begin
                r_rp <= r_rp + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_head_c  = r_mem[r_rp];
    assign o_full_c  = (r_cnt == CW'(DEPTH));
    assign o_empty_c = (r_cnt == '0);

endmodule

// File: rtl/axi_bridge_wr_arbiter.sv
// 2:1 AXI3 write-path arbiter: RR AW grant with CID tagging, W steering by grant order, B routing by CID.
// Optional outstanding-write limit enabled by AXI_BRIDGE_WR_ARB_OSTD_LIMIT_EN.
module axi_bridge_wr_arbiter
    import axi_bridge_wr_arbiter_pkg::*;
#(
    parameter int unsigned ORD_DEPTH = 4,
    parameter int unsigned MAX_OSTD  = 8
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic [2*AWU-1:0] S_AWPAY,
    input  logic [1:0]       S_AWVALID,
    output logic [1:0]       S_AWREADY,
    input  logic [2*WU-1:0]  S_WPAY,
    input  logic [1:0]       S_WVALID,
    output logic [1:0]       S_WREADY,
    output logic [2*BU-1:0]  S_BPAY,
    output logic [1:0]       S_BVALID,
    input  logic [1:0]       S_BREADY,
    output logic [AWM-1:0]   M_AWPAY,
    output logic             M_AWVALID,
    input  logic             M_AWREADY,
    output logic [WM-1:0]    M_WPAY,
    output logic             M_WVALID,
    input  logic             M_WREADY,
    input  logic [BM-1:0]    M_BPAY,
    input  logic             M_BVALID,
    output logic             M_BREADY,
    output logic             ERR_DROP
);

    // Illegal configurations elaborate this marker block so they stand out in the hierarchy.
    if (ORD_DEPTH < 2 || MAX_OSTD == 0) begin : g_cfg_illegal
    end

    aw_state_e               r_state;
    logic                    r_rr;
    logic                    w_grant;
    logic                    w_gnt_idx;
    logic                    w_lim_ok;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_head;
    logic                    w_pop;
    logic [AWU-1:0]          w_aw_sel;
    logic [WU-1:0]           w_w_sel;
    logic [AXI_WIDTH_CID-1:0] w_cid;

    assign w_gnt_idx = S_AWVALID[r_rr] ? r_rr : ~r_rr;
    assign w_grant   = ~ARESET && (r_state == ST_IDLE) && (|S_AWVALID) && ~w_full && w_lim_ok;
    assign w_aw_sel  = w_gnt_idx ? S_AWPAY[2*AWU-1 -: AWU] : S_AWPAY[AWU-1:0];
    assign S_AWREADY = w_grant ? (w_gnt_idx ? 2'b10 : 2'b01) : 2'b00;

    // AW FSM: capture on grant, hold until the downstream handshake.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state   <= ST_IDLE;
            r_rr      <= 1'b0;
            M_AWVALID <= 1'b0;
            M_AWPAY   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        M_AWPAY   <= {cid_enc(w_gnt_idx), w_aw_sel};
                        M_AWVALID <= 1'b1;
                        r_rr      <= ~w_gnt_idx;
                        r_state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (M_AWREADY) begin
                        M_AWVALID <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef AXI_BRIDGE_WR_ARB_OSTD_LIMIT_EN
    localparam int unsigned OW = $clog2(MAX_OSTD + 1);
    logic [OW-1:0] r_ostd;
    logic          w_bhs;

    assign w_bhs    = M_BVALID && M_BREADY;
    assign w_lim_ok = (r_ostd != OW'(MAX_OSTD));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_ostd <= '0;
        end else if (w_grant && !w_bhs) begin
            r_ostd <= r_ostd + OW'(1);
        end else if (!w_grant && w_bhs) begin
            r_ostd <= r_ostd - OW'(1);
        end
    end
`else
    assign w_lim_ok = 1'b1;
`endif

    axi_bridge_wr_arb_fifo #(
        .DEPTH (ORD_DEPTH),
        .DW    (1)
    ) u_ord_fifo (
        .i_clk     (ACLK),
        .i_rst     (ARESET),
        .i_push    (w_grant),
        .i_din     (w_gnt_idx),
        .i_pop     (w_pop),
        .o_head_c  (w_head),
        .o_full_c  (w_full),
        .o_empty_c (w_empty)
    );

    assign w_w_sel = w_head ? S_WPAY[2*WU-1 -: WU] : S_WPAY[WU-1:0];
    assign w_pop   = M_WVALID && M_WREADY && M_WPAY[0];

    // W steering follows the FIFO head; W may run ahead of the downstream AW.
    always_comb begin
        M_WVALID = 1'b0;
        M_WPAY   = '0;
        S_WREADY = 2'b00;
        if (!w_empty) begin
            M_WVALID         = S_WVALID[w_head];
            M_WPAY           = {cid_enc(w_head), w_w_sel};
            S_WREADY[w_head] = M_WREADY;
        end
    end

    assign w_cid = cid_dec(M_BPAY);

    // B routing by CID; unknown CIDs are sunk and flagged.
    always_comb begin
        S_BVALID = 2'b00;
        S_BPAY   = '0;
        M_BREADY = 1'b0;
        ERR_DROP = 1'b0;
        if (!ARESET) begin
            if (w_cid < AXI_WIDTH_CID'(2)) begin
                S_BVALID[w_cid[0]] = M_BVALID;
                M_BREADY           = S_BREADY[w_cid[0]];
                if (w_cid[0]) begin
                    S_BPAY[2*BU-1 -: BU] = M_BPAY[BU-1:0];
                end else begin
                    S_BPAY[BU-1:0] = M_BPAY[BU-1:0];
                end
            end else begin
                M_BREADY = 1'b1;
                ERR_DROP = M_BVALID;
            end
        end
    end

endmodule

// File: doc/axi_bridge_wr_arbiter.md
Name: axi_bridge_wr_arbiter

Overview:
- 2:1 AXI3 write-path arbiter placed in front of the bridge slave port. Two upstream masters share one downstream write interface (AW/W/B).
- Inserts the requester index into the CID field of the outgoing ID.
- Steers W beats in AW-grant order through an order FIFO.
- Routes B responses back to the requester by CID.

Parameters:
AXI_WIDTH_CID, 4, channel-ID field width; the requester index is zero-extended into it
AXI_WIDTH_ID, 4, upstream ID width
AXI_WIDTH_AD, 32, address width
AXI_WIDTH_DA, 32, data width; AXI_WIDTH_DS=AXI_WIDTH_DA/8
ORD_DEPTH, 4, order-FIFO entries (power of 2, ≥2)
MAX_OSTD, 8, outstanding-write limit (optional feature only)

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
S_AWPAY  in  2*AWU  per requester {AWID[ID],AWADDR,AWLEN[4],AWLOCK[2],AWSIZE[3],AWBURST[2]}; slice i = requester i
S_AWVALID / S_AWREADY  in/out  2  per-requester AW handshake
S_WPAY  in  2*WU  per requester {WID[ID],WDATA,WSTRB,WLAST}
S_WVALID / S_WREADY  in/out  2  per-requester W handshake
S_BPAY  out  2+ID+2 ... width 2*(ID+2)  per requester {BID,BRESP}
S_BVALID / S_BREADY  out/in  2  per-requester B handshake
M_AWPAY  out  AWM  same layout as S_AWPAY with SID=CID+ID ID field
M_AWVALID / M_AWREADY  out/in  1  downstream AW
M_WPAY  out  WM  {WID[SID],WDATA,WSTRB,WLAST}
M_WVALID / M_WREADY  out/in  1  downstream W
M_BPAY  in  SID+2  {BID,BRESP}
M_BVALID / M_BREADY  in/out  1  downstream B
ERR_DROP  out  1  one-cycle pulse when a B with CID≥2 is discarded

Behaviour:
- Reset: all outputs 0. RR pointer=0, FSM=IDLE, order FIFO empty, outstanding count=0. Reset mid-burst abandons all in-flight state; no recovery is attempted.
- AW FSM, IDLE:
  - Grant condition: some S_AWVALID=1 and FIFO not full (and limit not reached, see Optional Feature).
  - Winner: requester at RR pointer if valid, else the other one.
  - Same cycle: S_AWREADY[g]=1 (combinational), payload captured into M_AWPAY with ID={CID=g, upstream ID}, g pushed to FIFO, RR pointer ← ~g, go BUSY.
- AW FSM, BUSY: M_AWVALID=1, payload held stable. On M_AWREADY go IDLE. One bubble cycle between grants; S→M AW latency is 1 cycle.
- W steering:
  - FIFO empty: M_WVALID=0, all S_WREADY=0.
  - Otherwise, with h = FIFO head: M_WVALID=S_WVALID[h], M_WPAY=S_WPAY[h] with WID CID=h, S_WREADY[h]=M_WREADY, other S_WREADY=0. Purely combinational, zero latency.
  - On M_WVALID&M_WREADY&WLAST the FIFO pops.
  - W may precede the downstream AW; both are pushed at AW capture.
- FIFO push/pop in the same cycle is legal when non-empty. Push is never attempted when full (grant blocked).
- B routing:
  - c = M_BPAY CID field.
  - c∈{0,1}: S_BVALID[c]=M_BVALID, S_BPAY[c]={BID low ID bits, BRESP}, M_BREADY=S_BREADY[c].
  - c≥2: M_BREADY=1, response discarded, ERR_DROP pulses on the handshake.
  - Combinational, zero latency.
- Upstream WLAST is trusted; no beat counting against AWLEN.

Optional Feature:
- Macro: AXI_BRIDGE_WR_ARB_OSTD_LIMIT_EN.
- With the macro: a counter (width clog2(MAX_OSTD+1)) increments on AW capture and decrements on a downstream B handshake; simultaneous events leave it unchanged. Grant is blocked while count==MAX_OSTD.
- Without the macro: no counter; only FIFO full blocks grants.

Decomposition:
- Shared package/include: payload field offsets and widths (AWU, AWM, WU, WM), BRESP codes, CID encode/decode functions.
- One sub-module: axi_bridge_wr_arb_fifo, a synchronous FIFO of log2-index entries with ORD_DEPTH depth, full/empty flags and async active-high reset.

Test Plan:
- Single write: requester 0 issues AW ID=3 LEN=3, then 4 W beats → M_AWVALID one cycle after S_AWREADY[0]; M_AWPAY ID=0x03; M_WID=0x03; FIFO empty after the 4th beat; B ID=0x03 → S_BVALID[0].
- Contention: both S_AWVALID high for 4 grants → grant order 0,1,0,1 with one bubble between; W streams routed in the same order; M_WID CID alternates 0,1.
- FIFO full: ORD_DEPTH=4, 4 AWs granted with W withheld → 5th S_AWREADY stays 0 until the first WLAST handshake, then it is granted the next IDLE cycle.
- Backpressure: M_AWREADY low 5 cycles → M_AWPAY stable and M_AWVALID held; M_WREADY low → S_WREADY[h]=0.
- Bad CID: M_BVALID with BID CID=5 → M_BREADY=1, ERR_DROP=1 for one cycle, both S_BVALID=0.
- Limit (macro on, MAX_OSTD=2): 2 AWs without B → third blocked; one B handshake → third granted; ARESET mid-burst → all outputs 0 next cycle.
